// File: rtl/online_sd_adder_frame.sv
// rtl/online_sd_adder_frame.sv - framed radix-2 online signed-digit adder, online delay 2
// Optional on-the-fly result converter and self-check enabled by ONLINE_CONV_CHECK_EN.
module online_sd_adder_frame #(
  parameter int WIDTH = 4,
  localparam int SUMW = WIDTH + 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  input  logic            in_first,
  output logic            in_ready,
  input  logic            xp,
  input  logic            xn,
  input  logic            yp,
  input  logic            yn,
  output logic            zp,
  output logic            zn,
  output logic            out_valid,
  output logic            out_first,
  output logic            out_last,
  output logic            done,
  output logic [SUMW-1:0] sum1,
  output logic [SUMW-1:0] sum2,
  output logic [SUMW-1:0] sum_total,
  output logic            conv_err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH1, FLUSH2} state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic signed [2:0]       res;
  logic signed [SUMW-1:0]  acc_x;
  logic signed [SUMW-1:0]  acc_y;

  logic signed [1:0]       dx, dy, zsel;
  logic signed [2:0]       p_in, p_step;
  logic signed [3:0]       v, nres;
  logic signed [SUMW-1:0]  z_ext;
  logic                    accept, load, step;

  function automatic logic signed [1:0] sd_val(input logic p, input logic n);
    if (p && !n)      return 2'sd1;
    else if (n && !p) return -2'sd1;
    else              return 2'sd0;
  endfunction

  assign in_ready = reset && (state == IDLE || state == RUN);
  assign accept   = in_valid && in_ready;
  assign load     = accept && in_first;
  assign step     = (state == RUN && accept && !in_first) || state == FLUSH1 || state == FLUSH2;

  // Residual res = 2^j * (value so far - emitted so far), kept in [-2,2]; it is a
  // multiple of 4 after the last flush step, so it ends at exactly 0.
  always_comb begin
    dx     = sd_val(xp, xn);
    dy     = sd_val(yp, yn);
    p_in   = {dx[1], dx} + {dy[1], dy};
    p_step = (state == RUN) ? p_in : 3'sd0;
    v      = ({res[2], res} <<< 1) + {p_step[2], p_step};
    if (v >= 4'sd2)       zsel = 2'sd1;
    else if (v <= -4'sd2) zsel = -2'sd1;
    else                  zsel = 2'sd0;
    nres   = v - ({{2{zsel[1]}}, zsel} <<< 2);
    z_ext  = {{(SUMW-2){zsel[1]}}, zsel};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      res       <= '0;
      acc_x     <= '0;
      acc_y     <= '0;
      zp        <= 1'b0;
      zn        <= 1'b0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      sum1      <= '0;
      sum2      <= '0;
      sum_total <= '0;
    end else begin
      zp        <= 1'b0;
      zn        <= 1'b0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      if (load) begin
        // Also the abort path: a new first digit in RUN restarts from scratch.
        state <= RUN;
        cnt   <= CW'(1);
        res   <= p_in;
        acc_x <= {{(SUMW-2){dx[1]}}, dx};
        acc_y <= {{(SUMW-2){dy[1]}}, dy};
      end else if (step) begin
        out_valid <= 1'b1;
        zp        <= (zsel == 2'sd1);
        zn        <= (zsel == -2'sd1);
        res       <= nres[2:0];
        case (state)
          RUN: begin
            cnt       <= cnt + CW'(1);
            acc_x     <= (acc_x <<< 1) + {{(SUMW-2){dx[1]}}, dx};
            acc_y     <= (acc_y <<< 1) + {{(SUMW-2){dy[1]}}, dy};
            out_first <= (cnt == CW'(1));
            if (cnt == CW'(WIDTH - 1)) state <= FLUSH1;
          end
          FLUSH1: state <= FLUSH2;
          FLUSH2: begin
            state     <= IDLE;
            out_last  <= 1'b1;
            done      <= 1'b1;
            sum1      <= acc_x;
            sum2      <= acc_y;
            sum_total <= acc_x + acc_y;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef ONLINE_CONV_CHECK_EN
  logic signed [SUMW-1:0] conv_acc;
  logic signed [SUMW-1:0] conv_next;

  assign conv_next = (conv_acc <<< 1) + z_ext;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      conv_acc <= '0;
      conv_err <= 1'b0;
    end else begin
      conv_err <= 1'b0;
      if (load) begin
        conv_acc <= '0;
      end else if (step) begin
        conv_acc <= conv_next;
        if (state == FLUSH2) conv_err <= (conv_next != (acc_x + acc_y));
      end
    end
  end
`else
  logic unused_z_ext;
  assign unused_z_ext = ^z_ext;
  assign conv_err     = 1'b0;
`endif

endmodule

// File: tb/tb_online_sd_adder_frame.sv
// tb/tb_online_sd_adder_frame.sv - randomized self-checking bench for online_sd_adder_frame
module tb_online_sd_adder_frame;

  localparam int W    = 4;
  localparam int SUMW = W + 2;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            in_valid = 1'b0, in_first = 1'b0;
  logic            xp = 1'b0, xn = 1'b0, yp = 1'b0, yn = 1'b0;
  logic            in_ready, zp, zn, out_valid, out_first, out_last, done, conv_err;
  logic [SUMW-1:0] sum1, sum2, sum_total;

  int total = 0;
  int bad   = 0;
  int fx[W];
  int fy[W];
  int prev_s1 = 0;
  int prev_s2 = 0;

  online_sd_adder_frame #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_first(in_first),
    .in_ready(in_ready), .xp(xp), .xn(xn), .yp(yp), .yn(yn), .zp(zp), .zn(zn),
    .out_valid(out_valid), .out_first(out_first), .out_last(out_last), .done(done),
    .sum1(sum1), .sum2(sum2), .sum_total(sum_total), .conv_err(conv_err)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Zero digits use both legal encodings, (0,0) and (1,1).
  function automatic logic [1:0] enc(input int d);
    if (d > 0)      return 2'b10;
    else if (d < 0) return 2'b01;
    else            return ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
  endfunction

  task automatic sample_z(inout int zv, inout int zc);
    int z;
    check("z_legal", int'(zp & zn), 0);
    check("first_flag", int'(out_first), int'(zc == 0));
    check("last_flag", int'(out_last), int'(zc == W));
    z  = zp ? 1 : (zn ? -1 : 0);
    zv = zv * 2 + z;
    zc++;
  endtask

  task automatic run_frame(input int gap);
    int ex, ey, zv, zc;
    ex = 0; ey = 0; zv = 0; zc = 0;
    for (int j = 0; j < W; j++) begin
      ex = ex * 2 + fx[j];
      ey = ey * 2 + fy[j];
    end
    for (int j = 0; j < W; j++) begin
      if (j > 0) begin
        for (int g = 0; g < gap; g++) begin
          in_valid = 1'b0;
          in_first = 1'b0;
          tick();
          check("gap_valid", int'(out_valid), 0);
          check("gap_z", int'(zp | zn), 0);
          check("gap_ready", int'(in_ready), 1);
        end
      end
      in_valid   = 1'b1;
      in_first   = (j == 0);
      {xp, xn}   = enc(fx[j]);
      {yp, yn}   = enc(fy[j]);
      tick();
      check("dig_valid", int'(out_valid), int'(j >= 1));
      check("no_done", int'(done), 0);
      check("hold_sum", int'($signed(sum_total)), prev_s1 + prev_s2);
      if (out_valid) sample_z(zv, zc);
    end
    in_valid = 1'b0;
    in_first = 1'b0;
    {xp, xn, yp, yn} = 4'b1010;
    check("flush1_ready", int'(in_ready), 0);
    tick();
    check("flush1_valid", int'(out_valid), 1);
    check("flush2_ready", int'(in_ready), 0);
    check("flush1_done", int'(done), 0);
    if (out_valid) sample_z(zv, zc);
    tick();
    check("flush2_valid", int'(out_valid), 1);
    check("done", int'(done), 1);
    if (out_valid) sample_z(zv, zc);
    check("z_count", zc, W + 1);
    check("z_value", zv, ex + ey);
    check("sum1", int'($signed(sum1)), ex);
    check("sum2", int'($signed(sum2)), ey);
    check("sum_total", int'($signed(sum_total)), ex + ey);
    check("conv_err", int'(conv_err), 0);
    check("idle_ready", int'(in_ready), 1);
    prev_s1 = ex;
    prev_s2 = ey;
  endtask

  task automatic set_frame(input int x0, x1, x2, x3, y0, y1, y2, y3);
    fx[0] = x0; fx[1] = x1; fx[2] = x2; fx[3] = x3;
    fy[0] = y0; fy[1] = y1; fy[2] = y2; fy[3] = y3;
  endtask

  task automatic drive_digit(input logic first);
    in_valid = 1'b1;
    in_first = first;
    {xp, xn} = enc(int'($urandom_range(0, 2)) - 1);
    {yp, yn} = enc(int'($urandom_range(0, 2)) - 1);
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, int'(in_ready), 0);
    check({tag, "_valid"}, int'(out_valid | out_first | out_last | done), 0);
    check({tag, "_z"}, int'(zp | zn), 0);
    check({tag, "_sums"}, int'(sum1 | sum2 | sum_total), 0);
    check({tag, "_conv"}, int'(conv_err), 0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b1;
    #1;
    check("release_ready", int'(in_ready), 1);
    @(negedge clock);

    // Back-to-back sequence of directed frames
    set_frame(1, 0, 0, 0, 1, 0, 0, 0);
    run_frame(0);
    set_frame(-1, -1, -1, -1, -1, -1, -1, -1);
    run_frame(0);
    set_frame(1, -1, 0, 1, -1, 1, 1, -1);
    run_frame(0);
    run_frame(2);

    // Abort: two digits of a frame, then a fresh in_first
    drive_digit(1'b1);
    drive_digit(1'b0);
    check("abort_pre_valid", int'(out_valid), 1);
    set_frame(1, 0, 0, 0, 1, 0, 0, 0);
    run_frame(0);

    // Reset mid-frame after digit 3
    drive_digit(1'b1);
    drive_digit(1'b0);
    drive_digit(1'b0);
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    check_all_zero("midreset");
    tick();
    reset   = 1'b1;
    prev_s1 = 0;
    prev_s2 = 0;
    @(negedge clock);
    set_frame(-1, -1, -1, -1, -1, -1, -1, -1);
    run_frame(0);

    for (int f = 0; f < 25; f++) begin
      for (int j = 0; j < W; j++) begin
        fx[j] = int'($urandom_range(0, 2)) - 1;
        fy[j] = int'($urandom_range(0, 2)) - 1;
      end
      run_frame(int'($urandom_range(0, 2)));
    end

    in_valid = 1'b0;
    tick();
    check("final_valid", int'(out_valid), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
